// File: rtl/bus_responder.sv
// Bus-cycle responder: decodes CPU memory/I/O cycles and turns them into
// backing-store requests with READY wait-state control and an INTA vector.
module bus_responder #(
  parameter logic [7:0]  MEM_MASK  = 8'h00,
  parameter logic [7:0]  MEM_MATCH = 8'h00,
  parameter bit          IO_EN     = 1'b1,
  parameter int unsigned MIN_WAIT  = 0
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        ALE,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic        IOM,
  input  logic        DEN_n,
  input  logic        INTA_n,
  input  logic [7:0]  AD_in,
  input  logic [11:0] A,
  output logic [7:0]  AD_out,
  output logic        AD_oe,
  output logic        READY,
  output logic        req,
  output logic        req_we,
  output logic        req_io,
  output logic [19:0] req_addr,
  output logic [7:0]  req_wdata,
  input  logic        req_ack,
  input  logic [7:0]  req_rdata,
  input  logic [7:0]  irq_vector
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRIVE, HOLD, INTA} state_t;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        ad_oe_q, ad_oe_d;
  logic [7:0]  ad_out_q, ad_out_d;
  logic        we_q, we_d;
  logic        io_q, io_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        inta_cnt_q, inta_cnt_d;
  logic        inta_prev_q, inta_prev_d;
  logic        abort_q, abort_d;
  logic [19:0] lat_addr_q, lat_addr_d;
  logic        lat_iom_q, lat_iom_d;

  logic        sel;
  logic        strobe;
  logic        strobe_off;
  logic        inta_fall;
  logic [3:0]  wcnt_inc;
  logic        wait_done;

  assign strobe     = ~RD_n | ~WR_n;
  assign strobe_off = we_q ? WR_n : RD_n;
  assign inta_fall  = inta_prev_q & ~INTA_n;
  assign sel        = lat_iom_q ? IO_EN
                                : ((lat_addr_q[19:12] & MEM_MASK) == MEM_MATCH);
  assign wcnt_inc   = (wcnt_q == 4'hF) ? 4'hF : wcnt_q + 4'd1;
  assign wait_done  = 32'(wcnt_inc) >= MIN_WAIT;

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    ad_oe_d     = ad_oe_q;
    ad_out_d    = ad_out_q;
    we_d        = we_q;
    io_d        = io_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wcnt_d      = wcnt_q;
    abort_d     = abort_q;
    inta_prev_d = INTA_n;
    inta_cnt_d  = inta_fall ? ~inta_cnt_q : inta_cnt_q;
    lat_addr_d  = ALE ? {A, AD_in} : lat_addr_q;
    lat_iom_d   = ALE ? IOM : lat_iom_q;

    unique case (state_q)
      IDLE: begin
        if (inta_fall && inta_cnt_q) begin
          state_d  = INTA;
          ad_out_d = irq_vector;
          ad_oe_d  = ~DEN_n;
        end else if (strobe && sel) begin
          state_d = REQ;
          ready_d = 1'b0;
          we_d    = ~WR_n;
          io_d    = lat_iom_q;
          addr_d  = lat_addr_q;
          wcnt_d  = '0;
          abort_d = 1'b0;
          if (!WR_n) wdata_d = AD_in;
        end
      end
      REQ: begin
        wcnt_d = wcnt_inc;
        // An abandoned strobe releases the CPU at once; req still waits for ack.
        if (strobe_off) begin
          abort_d = 1'b1;
          ready_d = 1'b1;
        end
        if (req_ack) begin
          if (abort_q || strobe_off) begin
            state_d = IDLE;
          end else begin
            if (!we_q) ad_out_d = req_rdata;
            if (wait_done) begin
              ready_d = 1'b1;
              state_d = we_q ? HOLD : DRIVE;
              ad_oe_d = ~we_q & ~RD_n & ~DEN_n;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        wcnt_d = wcnt_inc;
        if (strobe_off) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (wait_done) begin
          ready_d = 1'b1;
          state_d = we_q ? HOLD : DRIVE;
          ad_oe_d = ~we_q & ~RD_n & ~DEN_n;
        end
      end
      DRIVE: begin
        ad_oe_d = ~RD_n & ~DEN_n;
        if (RD_n && WR_n) state_d = IDLE;
      end
      HOLD: begin
        if (RD_n && WR_n) state_d = IDLE;
      end
      INTA: begin
        ad_out_d = irq_vector;
        ad_oe_d  = ~INTA_n & ~DEN_n;
        if (INTA_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= '0;
      we_q        <= 1'b0;
      io_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wcnt_q      <= '0;
      inta_cnt_q  <= 1'b0;
      inta_prev_q <= 1'b1;
      abort_q     <= 1'b0;
      lat_addr_q  <= '0;
      lat_iom_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
      we_q        <= we_d;
      io_q        <= io_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wcnt_q      <= wcnt_d;
      inta_cnt_q  <= inta_cnt_d;
      inta_prev_q <= inta_prev_d;
      abort_q     <= abort_d;
      lat_addr_q  <= lat_addr_d;
      lat_iom_q   <= lat_iom_d;
    end
  end

  assign AD_out    = ad_out_q;
  assign AD_oe     = ad_oe_q;
  assign READY     = ready_q;
  assign req       = (state_q == REQ);
  assign req_we    = we_q;
  assign req_io    = io_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;

endmodule

// File: tb/tb_bus_responder.sv
// Randomized bench for bus_responder: three parameterisations share one bus and
// are checked against a transaction-level model (select rule, wait = max(ack, MIN_WAIT)).
module tb_bus_responder;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        ALE = 1'b0;
  logic        RD_n = 1'b1;
  logic        WR_n = 1'b1;
  logic        IOM = 1'b0;
  logic        DEN_n = 1'b1;
  logic        INTA_n = 1'b1;
  logic [7:0]  AD_in = '0;
  logic [11:0] A = '0;
  logic        req_ack = 1'b0;
  logic [7:0]  req_rdata = '0;
  logic [7:0]  irq_vector = 8'h08;

  logic [7:0]  ad_out [3];
  logic [2:0]  ad_oe, ready, req, req_we, req_io;
  logic [19:0] req_addr [3];
  logic [7:0]  req_wdata [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  bus_responder #(.MEM_MASK(8'h00), .MEM_MATCH(8'h00), .IO_EN(1'b1), .MIN_WAIT(0)) u_dut0 (
    .CLK(CLK), .RESET_n(RESET_n), .ALE(ALE), .RD_n(RD_n), .WR_n(WR_n), .IOM(IOM),
    .DEN_n(DEN_n), .INTA_n(INTA_n), .AD_in(AD_in), .A(A), .AD_out(ad_out[0]),
    .AD_oe(ad_oe[0]), .READY(ready[0]), .req(req[0]), .req_we(req_we[0]),
    .req_io(req_io[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ack(req_ack), .req_rdata(req_rdata), .irq_vector(irq_vector));

  bus_responder #(.MEM_MASK(8'h00), .MEM_MATCH(8'h00), .IO_EN(1'b1), .MIN_WAIT(4)) u_dut1 (
    .CLK(CLK), .RESET_n(RESET_n), .ALE(ALE), .RD_n(RD_n), .WR_n(WR_n), .IOM(IOM),
    .DEN_n(DEN_n), .INTA_n(INTA_n), .AD_in(AD_in), .A(A), .AD_out(ad_out[1]),
    .AD_oe(ad_oe[1]), .READY(ready[1]), .req(req[1]), .req_we(req_we[1]),
    .req_io(req_io[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ack(req_ack), .req_rdata(req_rdata), .irq_vector(irq_vector));

  bus_responder #(.MEM_MASK(8'hF0), .MEM_MATCH(8'hF0), .IO_EN(1'b1), .MIN_WAIT(0)) u_dut2 (
    .CLK(CLK), .RESET_n(RESET_n), .ALE(ALE), .RD_n(RD_n), .WR_n(WR_n), .IOM(IOM),
    .DEN_n(DEN_n), .INTA_n(INTA_n), .AD_in(AD_in), .A(A), .AD_out(ad_out[2]),
    .AD_oe(ad_oe[2]), .READY(ready[2]), .req(req[2]), .req_we(req_we[2]),
    .req_io(req_io[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_ack(req_ack), .req_rdata(req_rdata), .irq_vector(irq_vector));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int min_wait(input int i);
    return (i == 1) ? 4 : 0;
  endfunction

  task automatic check_reset(input int i);
    check($sformatf("i%0d rst READY", i), 32'(ready[i]), 32'd1);
    check($sformatf("i%0d rst AD_oe", i), 32'(ad_oe[i]), 32'd0);
    check($sformatf("i%0d rst AD_out", i), 32'(ad_out[i]), 32'd0);
    check($sformatf("i%0d rst req", i), 32'(req[i]), 32'd0);
    check($sformatf("i%0d rst req_we", i), 32'(req_we[i]), 32'd0);
    check($sformatf("i%0d rst req_io", i), 32'(req_io[i]), 32'd0);
    check($sformatf("i%0d rst req_addr", i), 32'(req_addr[i]), 32'd0);
    check($sformatf("i%0d rst req_wdata", i), 32'(req_wdata[i]), 32'd0);
  endtask

  // One CPU bus cycle; ack is sampled d edges after the strobe edge.
  task automatic xfer(input logic [19:0] addr, input logic iom, input logic wr,
                      input logic [7:0] wd, input int d, input logic [7:0] rd);
    logic sel [3];
    int   lows [3];
    int   reqs [3];
    int   oes  [3];
    int   len;
    int   exp_low;
    sel[0] = 1'b1;
    sel[1] = 1'b1;
    sel[2] = iom || ((addr[19:12] & 8'hF0) == 8'hF0);
    for (int i = 0; i < 3; i++) begin
      lows[i] = 0; reqs[i] = 0; oes[i] = 0;
    end
    len = ((d > 4) ? d : 4) + 2;
    ALE = 1'b1; A = addr[19:8]; AD_in = addr[7:0]; IOM = iom;
    @(posedge CLK); #1;
    ALE = 1'b0; AD_in = wr ? wd : 8'h00; DEN_n = 1'b0;
    if (wr) WR_n = 1'b0; else RD_n = 1'b0;
    for (int k = 0; k < len; k++) begin
      @(posedge CLK); #1;
      for (int i = 0; i < 3; i++) begin
        if (!ready[i]) lows[i]++;
        if (req[i]) reqs[i]++;
        if (ad_oe[i]) oes[i]++;
        if (sel[i] && k == 0) begin
          check($sformatf("i%0d req", i), 32'(req[i]), 32'd1);
          check($sformatf("i%0d req_addr", i), 32'(req_addr[i]), 32'(addr));
          check($sformatf("i%0d req_we", i), 32'(req_we[i]), 32'(wr));
          check($sformatf("i%0d req_io", i), 32'(req_io[i]), 32'(iom));
          if (wr) check($sformatf("i%0d req_wdata", i), 32'(req_wdata[i]), 32'(wd));
        end
      end
      req_ack   = (k == d - 1);
      req_rdata = (k == d - 1) ? rd : 8'h00;
      // A stray ALE mid-transfer must not reach req_addr; top nibble kept so select is unchanged.
      ALE = (k == 0);
      if (k == 0) A = {addr[19:16], ~addr[15:8]};
    end
    for (int i = 0; i < 3; i++) begin
      exp_low = !sel[i] ? 0 : ((d > min_wait(i)) ? d : min_wait(i));
      check($sformatf("i%0d READY low cycles", i), 32'(lows[i]), 32'(exp_low));
      if (!sel[i]) begin
        check($sformatf("i%0d unselected req", i), 32'(reqs[i]), 32'd0);
        check($sformatf("i%0d unselected AD_oe", i), 32'(oes[i]), 32'd0);
      end else begin
        check($sformatf("i%0d req cycles", i), 32'(reqs[i]), 32'(d));
        check($sformatf("i%0d req_addr held", i), 32'(req_addr[i]), 32'(addr));
        if (!wr) begin
          check($sformatf("i%0d AD_out", i), 32'(ad_out[i]), 32'(rd));
          check($sformatf("i%0d AD_oe drive", i), 32'(ad_oe[i]), 32'd1);
        end else begin
          check($sformatf("i%0d write AD_oe", i), 32'(oes[i]), 32'd0);
        end
      end
    end
    RD_n = 1'b1; WR_n = 1'b1; DEN_n = 1'b1; req_ack = 1'b0;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("i%0d AD_oe release", i), 32'(ad_oe[i]), 32'd0);
      check($sformatf("i%0d READY idle", i), 32'(ready[i]), 32'd1);
    end
    @(posedge CLK); #1;
  endtask

  task automatic inta_pulse(input logic resp);
    INTA_n = 1'b0; DEN_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("i%0d INTA AD_oe", i), 32'(ad_oe[i]), 32'(resp));
        if (resp) check($sformatf("i%0d INTA vector", i), 32'(ad_out[i]), 32'(irq_vector));
      end
    end
    INTA_n = 1'b1; DEN_n = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("i%0d INTA release", i), 32'(ad_oe[i]), 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int nz;
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) check_reset(i);
    RESET_n = 1'b1;
    @(posedge CLK); #1;

    xfer(20'h12345, 1'b0, 1'b0, 8'h00, 3, 8'hA5);
    xfer(20'h00061, 1'b1, 1'b1, 8'h3C, 1, 8'h00);

    for (int t = 0; t < 40; t++) begin
      logic [19:0] ad;
      ad = 20'($urandom);
      if ($urandom_range(0, 1) == 1) ad[19:16] = 4'hF;
      xfer(ad, 1'($urandom), 1'($urandom), 8'($urandom),
           int'($urandom_range(1, 6)), 8'($urandom));
    end

    // Strobe withdrawn before ack: READY released, req held until ack, no drive.
    ALE = 1'b1; A = 12'h123; AD_in = 8'h45; IOM = 1'b0;
    @(posedge CLK); #1;
    ALE = 1'b0; RD_n = 1'b0; DEN_n = 1'b0;
    @(posedge CLK); #1;
    RD_n = 1'b1; DEN_n = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("i%0d abort READY", i), 32'(ready[i]), 32'd1);
      check($sformatf("i%0d abort req held", i), 32'(req[i]), 32'd1);
    end
    @(posedge CLK); #1;
    req_ack = 1'b1; req_rdata = 8'h77;
    @(posedge CLK); #1;
    req_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("i%0d abort req drop", i), 32'(req[i]), 32'd0);
      check($sformatf("i%0d abort AD_oe", i), 32'(ad_oe[i]), 32'd0);
    end
    @(posedge CLK); #1;

    inta_pulse(1'b0);

    // Reset while the MIN_WAIT=4 instance is in WAIT, then a late ack.
    ALE = 1'b1; A = 12'h123; AD_in = 8'h45; IOM = 1'b0;
    @(posedge CLK); #1;
    ALE = 1'b0; RD_n = 1'b0; DEN_n = 1'b0;
    @(posedge CLK); #1;
    req_ack = 1'b1; req_rdata = 8'h5A;
    @(posedge CLK); #1;
    check("i1 in WAIT READY", 32'(ready[1]), 32'd0);
    req_ack = 1'b0; RESET_n = 1'b0; RD_n = 1'b1; DEN_n = 1'b1;
    @(posedge CLK); #1;
    RESET_n = 1'b1; req_ack = 1'b1;
    for (int i = 0; i < 3; i++) check_reset(i);
    @(posedge CLK); #1;
    req_ack = 1'b0;
    for (int i = 0; i < 3; i++) check_reset(i);
    nz = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      for (int i = 0; i < 3; i++) if (req[i] || !ready[i] || ad_oe[i]) nz++;
    end
    check("post-reset ack ignored", 32'(nz), 32'd0);

    inta_pulse(1'b0);
    inta_pulse(1'b1);
    inta_pulse(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
